// File: rtl/mem_lsu_stage_pkg.sv
// mem_lsu_stage_pkg: shared op encodings, FSM states and reset/write-back constants.
package mem_lsu_stage_pkg;
  localparam int MemOpLen = 4;
  localparam int RegAddrLen = 5;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic ResetEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;
  typedef enum logic [MemOpLen-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane steering/byte enables, load lane select/extension, alignment check.
module mem_align
  import mem_lsu_stage_pkg::*;
(
  input  logic [MemOpLen-1:0] op_i,
  input  logic [1:0]          off_i,
  input  logic [31:0]         wdata_i,
  input  logic [MemOpLen-1:0] ld_op_i,
  input  logic [1:0]          ld_off_i,
  input  logic [31:0]         rdata_i,
  output logic [31:0]         st_wdata_o,
  output logic [3:0]          be_o,
  output logic                misalign_o,
  output logic [31:0]         ld_data_o
);
  logic is_byte, is_half, is_word;
  logic [31:0] sh;
  always_comb begin
    is_byte = op_i == MEM_LB || op_i == MEM_LBU || op_i == MEM_SB;
    is_half = op_i == MEM_LH || op_i == MEM_LHU || op_i == MEM_SH;
    is_word = op_i == MEM_LW || op_i == MEM_SW;
    st_wdata_o = is_byte ? {4{wdata_i[7:0]}} : is_half ? {2{wdata_i[15:0]}} : wdata_i;
    be_o = is_byte ? 4'b0001 << off_i : is_half ? 4'b0011 << off_i : 4'b1111;
    misalign_o = (is_half && off_i[0]) || (is_word && off_i != 2'b00);
    // aligned words have offset 0, so the shifted word is the word itself
    sh = rdata_i >> {ld_off_i, 3'b000};
    ld_data_o = ld_op_i == MEM_LB  ? {{24{sh[7]}}, sh[7:0]} :
                ld_op_i == MEM_LH  ? {{16{sh[15]}}, sh[15:0]} :
                ld_op_i == MEM_LBU ? {24'h0, sh[7:0]} :
                ld_op_i == MEM_LHU ? {16'h0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/mem_lsu_stage.sv
// mem_lsu_stage: MEM stage with ALU pass-through and a handshaked load/store unit with timeout.
module mem_lsu_stage
  import mem_lsu_stage_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int REG_ADDR_W  = RegAddrLen
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     rd_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  rd_enable_i,
  input  logic [MemOpLen-1:0]   mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  rd_enable_o,
  output logic                  stall_req_o,
  output logic                  misalign_o,
  output logic                  bus_err_o
);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;
  if (DATA_W != 32) begin : g_bad_data_w
    $error("mem_lsu_stage: DATA_W must be 32");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_lsu_stage: TIMEOUT_CYC must be >= 1");
  end
  lsu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic req_q, req_d, we_q, we_d, rd_en_q, rd_en_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, ld_data_q, ld_data_d;
  logic [3:0] be_q, be_d;
  logic [MemOpLen-1:0] op_q, op_d;
  logic [1:0] off_q, off_d;
  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [31:0] st_wdata, ld_data;
  logic [3:0] st_be;
  logic mis, is_mem, is_store, launch;

  mem_align u_align (
    .op_i      (mem_op_i),
    .off_i     (mem_addr_i[1:0]),
    .wdata_i   (mem_wdata_i),
    .ld_op_i   (op_q),
    .ld_off_i  (off_q),
    .rdata_i   (mem_rdata_i),
    .st_wdata_o(st_wdata),
    .be_o      (st_be),
    .misalign_o(mis),
    .ld_data_o (ld_data)
  );

  always_comb begin
    is_mem = mem_op_i >= MEM_LB && mem_op_i <= MEM_SW;
    is_store = mem_op_i >= MEM_SB && mem_op_i <= MEM_SW;
    launch = state_q == S_IDLE && is_mem && !mis;
    state_d = state_q;
    cnt_d = cnt_q;
    req_d = req_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    op_d = op_q;
    off_d = off_q;
    rd_addr_d = rd_addr_q;
    rd_en_d = rd_en_q;
    ld_data_d = ld_data_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: if (launch) begin
        state_d = S_BUSY;
        cnt_d = '0;
        req_d = 1'b1;
        we_d = is_store;
        addr_d = {mem_addr_i[ADDR_W-1:2], 2'b00};
        wdata_d = st_wdata;
        be_d = st_be;
        op_d = mem_op_i;
        off_d = mem_addr_i[1:0];
        rd_addr_d = rd_addr_i;
        rd_en_d = rd_enable_i;
        ld_data_d = ZERO_WORD;
        err_d = 1'b0;
      end
      S_BUSY: if (mem_ack_i) begin
        state_d = S_DONE;
        req_d = 1'b0;
        ld_data_d = we_q ? ZERO_WORD : ld_data;
      end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        state_d = S_DONE;
        req_d = 1'b0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      req_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      op_q <= MEM_NONE;
      off_q <= '0;
      rd_addr_q <= '0;
      rd_en_q <= WriteDisable;
      ld_data_q <= ZERO_WORD;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      op_q <= op_d;
      off_q <= off_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q <= rd_en_d;
      ld_data_q <= ld_data_d;
      err_q <= err_d;
    end
  end

  // reset forces every output low combinationally, independent of state
  always_comb begin
    mem_req_o = !rst && req_q;
    mem_we_o = !rst && we_q;
    mem_addr_o = rst ? '0 : addr_q;
    mem_wdata_o = rst ? '0 : wdata_q;
    mem_be_o = rst ? '0 : be_q;
    stall_req_o = !rst && (state_q == S_BUSY || launch);
    misalign_o = !rst && state_q == S_IDLE && is_mem && mis;
    bus_err_o = !rst && state_q == S_DONE && err_q;
    rd_data_o = rst ? ZERO_WORD : state_q == S_DONE ? ld_data_q : rd_data_i;
    rd_addr_o = rst ? '0 : state_q == S_DONE ? rd_addr_q : rd_addr_i;
    rd_enable_o = rst ? WriteDisable :
                  state_q == S_DONE ? rd_en_q && !we_q && !err_q :
                  state_q == S_IDLE && !is_mem && rd_enable_i;
  end
endmodule

// File: tb/tb_mem_lsu_stage.sv
// tb_mem_lsu_stage: randomized and directed checks of mem_lsu_stage against a behavioural model.
module tb_mem_lsu_stage;
  import mem_lsu_stage_pkg::*;
  localparam int T = 16;
  logic clk, rst;
  logic [31:0] rd_data_i, mem_addr_i, mem_wdata_i, mem_rdata_i;
  logic [4:0] rd_addr_i;
  logic rd_enable_i, mem_ack_i;
  logic [3:0] mem_op_i;
  logic mem_req_o, mem_we_o, rd_enable_o, stall_req_o, misalign_o, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, rd_data_o;
  logic [3:0] mem_be_o;
  logic [4:0] rd_addr_o;
  int total, bad;

  mem_lsu_stage #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i),
    .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o),
    .stall_req_o(stall_req_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned op_size(input logic [3:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_model(input logic [3:0] op, input int unsigned off, input logic [31:0] rdata);
    logic [31:0] s;
    s = rdata >> (8 * off);
    case (op)
      MEM_LB:  return ((s & 32'hFF) ^ 32'h80) - 32'h80;
      MEM_LH:  return ((s & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      MEM_LBU: return s & 32'hFF;
      MEM_LHU: return s & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one EX/MEM instruction; ack_at = BUSY cycle that acks (0 or >T means never)
  task automatic xact(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int ack_at);
    int unsigned n, off, busy;
    logic [31:0] rv, exp_wd;
    logic [4:0] ra;
    logic re, st, tmo;
    n = op_size(op);
    off = addr % 4;
    rv = $urandom;
    ra = 5'($urandom);
    re = 1'($urandom);
    st = op == MEM_SB || op == MEM_SH || op == MEM_SW;
    cyc();
    mem_op_i = op; mem_addr_i = addr; mem_wdata_i = wdata;
    rd_data_i = rv; rd_addr_i = ra; rd_enable_i = re;
    mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
    #1;
    if (n == 0) begin
      check("pass_data", rd_data_o, rv);
      check("pass_addr", 32'(rd_addr_o), 32'(ra));
      check("pass_en", 32'(rd_enable_o), 32'(re));
      check("pass_stall", 32'(stall_req_o), 0);
      check("pass_req", 32'(mem_req_o), 0);
      check("pass_mis", 32'(misalign_o), 0);
      return;
    end
    if (addr % n != 0) begin
      check("mis_flag", 32'(misalign_o), 1);
      check("mis_stall", 32'(stall_req_o), 0);
      check("mis_req", 32'(mem_req_o), 0);
      check("mis_en", 32'(rd_enable_o), 0);
      return;
    end
    check("idle_stall", 32'(stall_req_o), 1);
    check("idle_en", 32'(rd_enable_o), 0);
    check("idle_req", 32'(mem_req_o), 0);
    check("idle_mis", 32'(misalign_o), 0);
    tmo = !(ack_at >= 1 && ack_at <= T);
    busy = tmo ? T : ack_at;
    exp_wd = n == 1 ? (wdata & 32'hFF) * 32'h01010101 : n == 2 ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
    for (int k = 1; k <= int'(busy); k++) begin
      cyc();
      mem_ack_i = k == ack_at;
      mem_rdata_i = k == ack_at ? rdata : $urandom;
      #1;
      check("busy_req", 32'(mem_req_o), 1);
      check("busy_stall", 32'(stall_req_o), 1);
      check("busy_en", 32'(rd_enable_o), 0);
      check("busy_err", 32'(bus_err_o), 0);
      check("busy_we", 32'(mem_we_o), 32'(st));
      check("busy_addr", mem_addr_o, addr & ~32'h3);
      check("busy_be", 32'(mem_be_o), ((32'h1 << n) - 1) << off);
      if (st) check("busy_wdata", mem_wdata_o, exp_wd);
    end
    cyc();
    mem_ack_i = 1'($urandom); mem_rdata_i = $urandom;
    #1;
    check("done_stall", 32'(stall_req_o), 0);
    check("done_req", 32'(mem_req_o), 0);
    check("done_err", 32'(bus_err_o), 32'(tmo));
    check("done_en", 32'(rd_enable_o), 32'(re && !st && !tmo));
    if (!st && !tmo) begin
      check("done_data", rd_data_o, load_model(op, off, rdata));
      check("done_raddr", 32'(rd_addr_o), 32'(ra));
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    mem_op_i = MEM_NONE; mem_addr_i = 0; mem_wdata_i = 0; mem_rdata_i = 0; mem_ack_i = 0;
    rd_data_i = 32'hDEADBEEF; rd_addr_i = 5'd3; rd_enable_i = 1'b1;
    cyc(); cyc();
    check("rst_data", rd_data_o, 0);
    check("rst_en", 32'(rd_enable_o), 0);
    check("rst_stall", 32'(stall_req_o), 0);
    check("rst_req", 32'(mem_req_o), 0);
    rst = 1'b0;
    cyc();
    rd_data_i = 32'h12345678; rd_addr_i = 5'd5; rd_enable_i = 1'b1;
    #1;
    check("tp_pass_data", rd_data_o, 32'h12345678);
    check("tp_pass_addr", 32'(rd_addr_o), 5);
    check("tp_pass_en", 32'(rd_enable_o), 1);
    xact(MEM_LB, 32'h1003, 0, 32'h80FF0000, 3);
    xact(MEM_LBU, 32'h1003, 0, 32'h80FF0000, 3);
    xact(MEM_SH, 32'h2002, 32'h0000BEEF, 0, 2);
    xact(MEM_LW, 32'h3001, 0, 0, 1);
    xact(MEM_LW, 32'h4000, 0, 32'h11223344, 0);
    xact(MEM_NONE, 0, 0, 0, 0);
    xact(MEM_LW, 32'h5000, 0, 32'hCAFEF00D, T);
    xact(MEM_LH, 32'h6002, 0, 32'h8001FFFF, 1);
    // reset in the middle of a BUSY word load
    cyc();
    mem_op_i = MEM_LW; mem_addr_i = 32'h7000; rd_enable_i = 1'b1; mem_ack_i = 1'b0;
    cyc(); cyc();
    rst = 1'b1; mem_op_i = MEM_NONE;
    #1;
    check("rstb_req", 32'(mem_req_o), 0);
    check("rstb_en", 32'(rd_enable_o), 0);
    cyc();
    rst = 1'b0; rd_enable_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
    #1;
    check("rstb_req2", 32'(mem_req_o), 0);
    check("rstb_stall2", 32'(stall_req_o), 0);
    check("rstb_en2", 32'(rd_enable_o), 0);
    cyc();
    #1;
    check("rstb_req3", 32'(mem_req_o), 0);
    check("rstb_en3", 32'(rd_enable_o), 0);
    mem_ack_i = 1'b0;
    for (int i = 0; i < 120; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 2 == 0) a = a & ~32'h3;
      xact(4'($urandom_range(0, 8)), a, $urandom, $urandom,
           ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 5)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
- Next-generation MEM stage of the pipeline, between the EX/MEM and MEM/WB registers.
- Passes ALU results through to write-back with zero latency, as before.
- Adds a real load/store unit: byte/half/word loads and stores, a multi-cycle memory request/acknowledge handshake, and pipeline stall generation.
- Adds misalignment detection and an acknowledge timeout that flags a bus error.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, register/memory data width; only 32 is supported (elaboration-time check).
- TIMEOUT_CYC, 16, maximum cycles in BUSY without mem_ack_i before a bus error; must be ≥ 1.
- REG_ADDR_W, 5, destination register index width (`RegAddrLen`).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset (`ResetEnable` = 1).
- rd_data_i  in  DATA_W  ALU result from EX/MEM.
- rd_addr_i  in  REG_ADDR_W  destination register.
- rd_enable_i  in  1  write-back enable.
- mem_op_i  in  4  memory operation: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
- mem_addr_i  in  ADDR_W  effective address.
- mem_wdata_i  in  DATA_W  store data (rs2).
- mem_req_o  out  1  memory request, registered, held until acknowledged.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  ADDR_W  word-aligned address (addr[1:0] = 0).
- mem_wdata_o  out  DATA_W  store data shifted into the addressed byte lanes.
- mem_be_o  out  DATA_W/8  byte enables.
- mem_rdata_i  in  DATA_W  read data, valid when mem_ack_i = 1.
- mem_ack_i  in  1  transfer complete.
- rd_data_o  out  DATA_W  to write-back.
- rd_addr_o  out  REG_ADDR_W  to write-back.
- rd_enable_o  out  1  to write-back.
- stall_req_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- misalign_o  out  1  one-cycle flag: misaligned access.
- bus_err_o  out  1  one-cycle flag: acknowledge timeout.

Behaviour:
- Reset (rst = 1 at a clk edge):
  - state → IDLE; timeout counter cleared; request registers cleared.
  - While rst = 1: all outputs forced to 0 combinationally, i.e. rd_data_o = ZERO_WORD, rd_enable_o = WriteDisable, and mem_req_o, stall_req_o, misalign_o, bus_err_o all 0.
  - Reset during BUSY abandons the transfer; a late mem_ack_i is ignored.
- FSM states: IDLE, BUSY, DONE.
- IDLE, mem_op_i = NONE:
  - Combinational pass-through of rd_data/rd_addr/rd_enable.
  - stall_req_o = 0; latency 0.
- IDLE, memory op, misaligned (LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] ≠ 0):
  - No request is issued; misalign_o = 1 this cycle.
  - rd_enable_o = 0; stall_req_o = 0; state stays IDLE.
- IDLE, memory op, aligned:
  - stall_req_o = 1 combinationally; rd_enable_o = 0.
  - At the clk edge: capture op, lane offset, rd_addr_i and the formatted request; mem_req_o ← 1; counter ← 0; state → BUSY.
- BUSY:
  - stall_req_o = 1; mem_req_o and all request fields held stable.
  - mem_ack_i = 1: latch formatted load data (stores: none); mem_req_o ← 0; state → DONE.
  - Else, counter = TIMEOUT_CYC − 1: mem_req_o ← 0; bus_err_o asserted for one cycle while in DONE; write-back suppressed; state → DONE.
  - Else: counter increments.
- DONE:
  - stall_req_o = 0, so the pipeline advances at this edge.
  - Loads: rd_data_o = formatted data, rd_addr_o = captured address, rd_enable_o = captured enable.
  - Stores and timeouts: rd_enable_o = 0.
  - state → IDLE. The still-present EX/MEM op is not relaunched.
- Ack timing: mem_ack_i is ignored in IDLE and DONE. Minimum load/store latency is 2 cycles of stall (IDLE, BUSY with ack) + the DONE cycle.
- Store formatting (off = addr[1:0]):
  - SB: be = 1 << off; data byte replicated to all lanes.
  - SH: be = 0b11 << off; halfword replicated to both halves.
  - SW: be = 0xF.
- Load formatting: select the byte/half at off. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Arithmetic is all unsigned; the counter is width $clog2(TIMEOUT_CYC) + 1.

Decomposition:
- Shared config include:
  - mem_op encodings (`MemOpLen` = 4, `MEM_NONE` … `MEM_SW`).
  - FSM state codes.
  - existing `ZERO_WORD`, `ResetEnable`, `WriteDisable`.
- Sub-module mem_align, purely combinational:
  - store lane steering + byte enables.
  - load lane select + sign/zero extension.
  - alignment check.
- mem_lsu_stage holds the FSM, the timeout counter and the capture registers.

Test Plan:
- Pass-through: mem_op_i = NONE, rd_data_i = 0x12345678, rd_addr_i = 5, rd_enable_i = 1 → same values on outputs that cycle; stall_req_o = 0; mem_req_o = 0.
- LB sign-extend: addr 0x1003, ack after 3 BUSY cycles with rdata 0x80FF0000 → stall high 4 cycles; DONE gives rd_data_o = 0xFFFFFF80, rd_enable_o = 1. Same with LBU → 0x00000080.
- SH at addr 0x2002, wdata 0x0000BEEF → mem_addr_o = 0x2000, mem_be_o = 0b1100, mem_wdata_o = 0xBEEFBEEF, mem_we_o = 1; DONE has rd_enable_o = 0.
- Misaligned LW at addr 0x3001 → misalign_o = 1 for one cycle, mem_req_o stays 0, stall_req_o = 0, rd_enable_o = 0.
- Timeout: LW, no ack, TIMEOUT_CYC = 16 → mem_req_o high exactly 16 cycles; bus_err_o pulses one cycle in DONE; rd_enable_o = 0; a late ack is ignored.
- Reset mid-BUSY: rst = 1 for one edge during LW → next cycle state IDLE, mem_req_o = 0, stall_req_o = 0; a subsequent ack produces no write-back.
